if_prefetch_stage: RTL and testbench

- Parametrised successor to the single-entry instruction fetch stage.
- Issues pipelined sequential fetches to instruction memory with up to MAX_OUTSTANDING requests in flight, and buffers returned instructions in a DEPTH-entry FIFO feeding decode.
- On a redirect (branch/jump/flush), it discards queued entries and squashes in-flight responses.
- Sits between instruction memory and id_stage; replaces the pc register and stall-based fetch.

---
 rtl/if_prefetch_stage.sv | 194 +++++++++++++++++++
 tb/tb_if_prefetch_stage.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch_stage.sv
// if_prefetch_stage
//   Instruction prefetch stage. It issues sequential fetches to instruction
//   memory with up to MAX_OUTSTANDING requests in flight. Returned words are
//   buffered in a DEPTH-entry first-word-fall-through FIFO that feeds decode.
//   A redirect clears the FIFO and restarts fetch at the target pc. It also
//   marks every in-flight response as stale so that it is dropped on arrival.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   i_redirect      redirect/flush request this cycle
//   i_redirect_pc   new fetch pc, taken when i_redirect=1 (word aligned)
//   i_id_ready      decode accepts the head entry this cycle
//   imem_addr       request address (always shows the current fetch pc)
//   imem_rmask      4'hF when a request is issued this cycle, otherwise 4'h0
//   imem_rdata      response instruction word
//   imem_resp       response valid; responses arrive in issue order
//   o_valid         head entry valid
//   o_pc            pc of the head entry
//   o_pc_next       o_pc + 4 (static not-taken prediction)
//   o_inst          instruction word of the head entry
//   o_count         number of entries in the FIFO

module if_prefetch_stage #(
  parameter logic [31:0] RESET_VECTOR    = 32'h6000_0000,
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_redirect,
  input  logic [31:0]              i_redirect_pc,
  input  logic                     i_id_ready,
  output logic [31:0]              imem_addr,
  output logic [3:0]               imem_rmask,
  input  logic [31:0]              imem_rdata,
  input  logic                     imem_resp,
  output logic                     o_valid,
  output logic [31:0]              o_pc,
  output logic [31:0]              o_pc_next,
  output logic [31:0]              o_inst,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);                                 // FIFO pointer width
  localparam int CW = PW + 1;                                        // FIFO count width
  localparam int SW = CW + 1;                                        // outstanding + count
  localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  // Back-to-back redirects can stack stale responses from several
  // generations of requests, so keep one bit of headroom above 2*MAX.
  localparam int DW = $clog2(2 * MAX_OUTSTANDING + 1) + 1;

  localparam logic [OW-1:0] MAX_OUT_W = OW'(MAX_OUTSTANDING);
  localparam logic [SW-1:0] DEPTH_S   = SW'(DEPTH);
  localparam logic [TW-1:0] TAG_LAST  = TW'(MAX_OUTSTANDING - 1);

  // Control state
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [TW-1:0] tag_rd_q, tag_rd_d;
  logic [TW-1:0] tag_wr_q, tag_wr_d;
  logic [OW-1:0] outstanding_q, outstanding_d;
  logic [DW-1:0] discard_q, discard_d;

  // Storage (no reset, plain RAM-style arrays)
  logic [31:0] pc_mem   [DEPTH];
  logic [31:0] inst_mem [DEPTH];
  logic [31:0] tag_mem  [MAX_OUTSTANDING];

  logic          issue;
  logic          pop;
  logic          push;
  logic          resp_live;   // response belongs to the current generation
  logic          resp_drop;   // response belongs to a squashed generation
  logic          resp_any;
  logic [CW-1:0] count_after_pop;
  logic [SW-1:0] occupancy;

  function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] ptr);
    return (ptr == TAG_LAST) ? '0 : ptr + TW'(1);
  endfunction

  assign o_valid = (count_q != '0);
  assign pop     = o_valid && i_id_ready && !i_redirect && !rst;

  assign count_after_pop = count_q - CW'(pop);
  // In-flight requests reserve a FIFO slot, so an accepted response never
  // finds the FIFO full.
  assign occupancy = SW'(outstanding_q) + SW'(count_after_pop);
  assign issue     = !rst && !i_redirect && (outstanding_q < MAX_OUT_W) &&
                     (occupancy < DEPTH_S);

  // Responses are in issue order. Stale ones (counted by discard_q) are
  // always older than live ones, so they are consumed first.
  assign resp_drop = imem_resp && (discard_q != '0);
  assign resp_live = imem_resp && (discard_q == '0) && (outstanding_q != '0);
  assign resp_any  = resp_drop || resp_live;
  assign push      = resp_live && !i_redirect;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q + CW'(push) - CW'(pop);
    tag_rd_d      = tag_rd_q;
    tag_wr_d      = tag_wr_q;
    outstanding_d = outstanding_q + OW'(issue) - OW'(resp_live);
    discard_d     = discard_q;

    if (issue) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
      tag_wr_d   = tag_inc(tag_wr_q);
    end
    if (resp_live) begin
      tag_rd_d = tag_inc(tag_rd_q);
    end
    if (resp_drop) begin
      discard_d = discard_q - DW'(1);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    // Redirect: every request still in flight becomes stale. The response
    // arriving in this same cycle, whichever generation it belongs to, is
    // consumed here.
    if (i_redirect) begin
      fetch_pc_d    = i_redirect_pc;
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
      count_d       = '0;
      tag_rd_d      = '0;
      tag_wr_d      = '0;
      outstanding_d = '0;
      discard_d     = discard_q + DW'(outstanding_q) - DW'(resp_any);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_VECTOR;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      tag_rd_q      <= '0;
      tag_wr_q      <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      tag_rd_q      <= tag_rd_d;
      tag_wr_q      <= tag_wr_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  // The pc tag is captured at issue and paired with its data on return.
  always_ff @(posedge clk) begin
    if (issue) begin
      tag_mem[tag_wr_q] <= fetch_pc_q;
    end
    if (push) begin
      pc_mem[wr_ptr_q]   <= tag_mem[tag_rd_q];
      inst_mem[wr_ptr_q] <= imem_rdata;
    end
  end

  assign imem_addr  = fetch_pc_q;
  assign imem_rmask = issue ? 4'hF : 4'h0;

  // Head outputs read storage directly; they are forced to zero when empty
  // so that uninitialised storage never shows on the ports.
  assign o_pc      = o_valid ? pc_mem[rd_ptr_q] : 32'd0;
  assign o_pc_next = o_valid ? (pc_mem[rd_ptr_q] + 32'd4) : 32'd0;
  assign o_inst    = o_valid ? inst_mem[rd_ptr_q] : 32'd0;
  assign o_count   = count_q;

  // A response with nothing in flight means the memory broke protocol.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(imem_resp && (outstanding_q == '0) && (discard_q == '0)));
    end
  end

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Testbench for if_prefetch_stage. Directed phases drive reset, redirects,
// decode back-pressure and memory latency. Expected head pcs are queued when
// each phase starts. A monitor pops that queue on every accepted head entry
// and checks pc, pc_next and inst. The memory model checks every request
// address against the expected sequential fetch stream.

module tb_if_prefetch_stage;

  localparam logic [31:0] RV = 32'h6000_0000;

  logic        clk;
  logic        rst;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        i_id_ready;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        o_valid;
  logic [31:0] o_pc;
  logic [31:0] o_pc_next;
  logic [31:0] o_inst;
  logic [2:0]  o_count;

  if_prefetch_stage dut (
    .clk          (clk),
    .rst          (rst),
    .i_redirect   (i_redirect),
    .i_redirect_pc(i_redirect_pc),
    .i_id_ready   (i_id_ready),
    .imem_addr    (imem_addr),
    .imem_rmask   (imem_rmask),
    .imem_rdata   (imem_rdata),
    .imem_resp    (imem_resp),
    .o_valid      (o_valid),
    .o_pc         (o_pc),
    .o_pc_next    (o_pc_next),
    .o_inst       (o_inst),
    .o_count      (o_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard and shared bench state
  logic [31:0] exp_q[$];
  logic [31:0] exp_req_addr;
  int          n_popped = 0;
  int          req_cnt  = 0;
  int          max_pend = 0;
  int          max_cnt  = 0;
  int          mem_lat  = 1;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;
  req_t pend[$];

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] base, input int n);
    logic [31:0] pc;
    pc = base;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(pc);
      pc = pc + 32'd4;
    end
  endtask

  task automatic wait_pops(input string name, input int n);
    int target;
    int k;
    target = n_popped + n;
    k = 0;
    while (n_popped < target && k < 300) begin
      @(posedge clk);
      k++;
    end
    check(name, 32'(n_popped >= target), 32'd1);
  endtask

  task automatic redirect(input logic [31:0] pc);
    i_redirect    = 1'b1;
    i_redirect_pc = pc;
    exp_q.delete();
    exp_req_addr  = pc;
    @(posedge clk); #2;
    i_redirect    = 1'b0;
  endtask

  // Memory model: requests observed mid-cycle, responses presented just
  // after the edge, in order, mem_lat cycles after issue.
  initial begin
    int cyc;
    cyc        = 0;
    imem_resp  = 1'b0;
    imem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend.delete();
      end else if (imem_rmask == 4'hF) begin
        check("req_addr", imem_addr, exp_req_addr);
        $display("req  addr=%h", imem_addr);
        exp_req_addr = exp_req_addr + 32'd4;
        req_cnt++;
        pend.push_back('{imem_addr, cyc + mem_lat});
        if (pend.size() > max_pend) max_pend = pend.size();
      end
      @(posedge clk); #1;
      cyc++;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        imem_resp  = 1'b1;
        imem_rdata = inst_of(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        imem_resp  = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
      end
    end
  end

  // Monitor: compares every accepted head entry with the scoreboard.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (32'(o_count) > max_cnt) max_cnt = 32'(o_count);
        if (o_valid && i_id_ready && !i_redirect) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_unexpected: got pc %h expected no entry", o_pc);
          end else begin
            e = exp_q.pop_front();
            $display("pop  pc=%h inst=%h", o_pc, o_inst);
            check("pop_pc", o_pc, e);
            check("pop_pc_next", o_pc_next, e + 32'd4);
            check("pop_inst", o_inst, inst_of(e));
          end
          n_popped++;
        end
      end
    end
  end

  initial begin
    int k;
    rst           = 1'b1;
    i_redirect    = 1'b0;
    i_redirect_pc = 32'd0;
    i_id_ready    = 1'b0;
    exp_req_addr  = RV;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rmask", 32'(imem_rmask), 32'd0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_pc", o_pc, 32'd0);
    check("rst_pc_next", o_pc_next, 32'd0);
    check("rst_inst", o_inst, 32'd0);
    check("rst_count", 32'(o_count), 32'd0);

    // Phase 1: latency 1, decode always ready
    @(posedge clk); #2;
    rst        = 1'b0;
    i_id_ready = 1'b1;
    max_cnt    = 0;
    push_exp(RV, 64);
    wait_pops("p1_pops", 8);
    check("p1_count_le2", 32'(max_cnt <= 2), 32'd1);

    // Phase 2: decode stalled, FIFO fills to DEPTH
    @(posedge clk); #2;
    rst        = 1'b1;
    i_id_ready = 1'b0;
    exp_q.delete();
    exp_req_addr = RV;
    @(posedge clk); #2;
    rst     = 1'b0;
    req_cnt = 0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("p2_count_full", 32'(o_count), 32'd4);
    check("p2_valid", 32'(o_valid), 32'd1);
    check("p2_head_pc", o_pc, RV);
    check("p2_rmask_idle", 32'(imem_rmask), 32'd0);
    check("p2_req_cnt", 32'(req_cnt), 32'd4);
    @(posedge clk); #2;
    push_exp(RV, 64);
    i_id_ready = 1'b1;
    wait_pops("p2_pops", 6);

    // Phase 3: latency 3, in-flight limit
    mem_lat  = 3;
    max_pend = 0;
    wait_pops("p3_pops", 8);
    check("p3_max_inflight", 32'(max_pend), 32'd2);

    // Phase 4: redirect with requests in flight and entries queued
    @(posedge clk); #2;
    i_id_ready = 1'b0;
    k = 0;
    while (o_count < 3'd2 && k < 50) begin
      @(posedge clk); #2;
      k++;
    end
    check("p4_fill", 32'(o_count >= 3'd2), 32'd1);
    i_id_ready = 1'b1;
    redirect(32'h6000_0100);
    push_exp(32'h6000_0100, 64);
    @(negedge clk);
    check("p4_valid_clear", 32'(o_valid), 32'd0);
    check("p4_count_clear", 32'(o_count), 32'd0);
    wait_pops("p4_pops", 6);

    // Phase 5: redirect coinciding with a response, then a second redirect
    k = 0;
    @(posedge clk); #2;
    while (!imem_resp && k < 50) begin
      @(posedge clk); #2;
      k++;
    end
    check("p5_resp_seen", 32'(imem_resp), 32'd1);
    redirect(32'h6000_0180);
    @(posedge clk); #2;
    redirect(32'h6000_0200);
    push_exp(32'h6000_0200, 64);
    wait_pops("p5_pops", 6);

    // Phase 6: pc wrap at the top of the address space, then reset mid-burst
    mem_lat = 1;
    @(posedge clk); #2;
    redirect(32'hFFFF_FFFC);
    push_exp(32'hFFFF_FFFC, 64);
    wait_pops("p6_wrap_pops", 4);
    mem_lat = 2;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    exp_req_addr = RV;
    @(posedge clk); #2;
    rst = 1'b0;
    push_exp(RV, 64);
    @(negedge clk);
    check("p6_rst_count", 32'(o_count), 32'd0);
    check("p6_rst_valid", 32'(o_valid), 32'd0);
    wait_pops("p6_rst_pops", 4);

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
